// File: rtl/bam_seq_divider.sv
// Iterative restoring divider (2*WIDTH / WIDTH) for the broken-array multiplier product domain.
// Optional feature macro: BAM_DIV_ROUND_EN (round-half-up quotient on normal completion).
module bam_seq_divider #(
   parameter int WIDTH = 4,
   parameter int VBL   = 0
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [2*WIDTH-1:0]   dividend,
   input  logic [WIDTH-1:0]     divisor,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [WIDTH-1:0]     quotient,
   output logic [WIDTH-1:0]     remainder,
   output logic                 ovf,
   output logic                 dz
);

   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t               state_q, state_d;
   logic [2*WIDTH-1:0]   vbl_mask;
   logic [2*WIDTH-1:0]   dvd_masked;
   logic [WIDTH-1:0]     dvd_hi;
   logic [WIDTH-1:0]     lo_q, lo_d;
   logic [WIDTH-1:0]     dvs_q, dvs_d;
   logic [WIDTH-1:0]     p_q, p_d;
   logic [WIDTH-1:0]     q_q, q_d;
   logic [WIDTH-1:0]     rem_q, rem_d;
   logic [CW-1:0]        cnt_q, cnt_d;
   logic                 ovf_q, ovf_d;
   logic                 dz_q, dz_d;

   logic [WIDTH:0]       trial;
   logic [WIDTH-1:0]     diff;
   logic                 qbit;
   logic [WIDTH-1:0]     p_next;
   logic [WIDTH-1:0]     q_shift;

   // Columns below the vertical breaking level never carry product bits.
   generate
      for (genvar gi = 0; gi < 2*WIDTH; gi++) begin : g_mask
         assign vbl_mask[gi] = (gi >= VBL);
      end
   endgenerate

   assign dvd_masked = dividend & vbl_mask;
   assign dvd_hi     = dvd_masked[2*WIDTH-1:WIDTH];

   // The partial remainder is always below the divisor after a step, so only W bits
   // are stored; the trial value carries the extra top bit for the W+1-bit compare.
   always_comb begin
      trial   = {p_q, lo_q[cnt_q]};
      qbit    = (trial >= {1'b0, dvs_q});
      diff    = trial[WIDTH-1:0] - dvs_q;
      p_next  = qbit ? diff : trial[WIDTH-1:0];
      q_shift = (q_q << 1) | {{(WIDTH-1){1'b0}}, qbit};
   end

`ifdef BAM_DIV_ROUND_EN
   logic round_up;
   always_comb begin
      round_up = ({p_next, 1'b0} >= {1'b0, dvs_q}) && (q_shift != {WIDTH{1'b1}});
   end
`endif

   always_comb begin
      state_d = state_q;
      lo_d    = lo_q;
      dvs_d   = dvs_q;
      p_d     = p_q;
      q_d     = q_q;
      rem_d   = rem_q;
      cnt_d   = cnt_q;
      ovf_d   = ovf_q;
      dz_d    = dz_q;
      case (state_q)
         IDLE: begin
            if (in_valid) begin
               lo_d  = dvd_masked[WIDTH-1:0];
               dvs_d = divisor;
               if (divisor == '0) begin
                  dz_d    = 1'b1;
                  q_d     = '1;
                  rem_d   = '0;
                  state_d = DONE;
               end else if (dvd_hi >= divisor) begin
                  ovf_d   = 1'b1;
                  q_d     = '1;
                  rem_d   = '0;
                  state_d = DONE;
               end else begin
                  p_d     = dvd_hi;
                  q_d     = '0;
                  cnt_d   = CW'(WIDTH-1);
                  state_d = RUN;
               end
            end
         end
         RUN: begin
            p_d   = p_next;
            q_d   = q_shift;
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == '0) begin
               rem_d   = p_next;
               state_d = DONE;
`ifdef BAM_DIV_ROUND_EN
               q_d     = q_shift + {{(WIDTH-1){1'b0}}, round_up};
`endif
            end
         end
         DONE: begin
            if (out_ready) begin
               ovf_d   = 1'b0;
               dz_d    = 1'b0;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         lo_q    <= '0;
         dvs_q   <= '0;
         p_q     <= '0;
         q_q     <= '0;
         rem_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         dz_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         lo_q    <= lo_d;
         dvs_q   <= dvs_d;
         p_q     <= p_d;
         q_q     <= q_d;
         rem_q   <= rem_d;
         cnt_q   <= cnt_d;
         ovf_q   <= ovf_d;
         dz_q    <= dz_d;
      end
   end

   assign in_ready  = (state_q == IDLE);
   assign out_valid = (state_q == DONE);
   assign quotient  = q_q;
   assign remainder = rem_q;
   assign ovf       = ovf_q;
   assign dz        = dz_q;

endmodule
